// File: rtl/seq_divider_pkg.sv
// Shared datapath constants for the multicycle divider: operand width,
// iteration counter width, FSM encodings and the divide-by-zero exception code.
package seq_divider_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Exception code the controller raises when div_by_zero pulses.
  localparam logic [4:0] EXC_DIV_ZERO = 5'h0f;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_if.sv
// Divide handshake between the control unit (master) and the divider (slave):
// start pulse plus operands in, busy/completion/zero-flag and HI/LO results out.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = seq_divider_pkg::WIDTH
);

  logic             div_start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             div_end;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output div_start, dividend, divisor,
    input  busy, div_end, div_by_zero, hi, lo
  );

  modport slave (
    input  div_start, dividend, divisor,
    output busy, div_end, div_by_zero, hi, lo
  );

endinterface : seq_divider_if

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes: shifts the
// next dividend bit into the partial remainder and produces one quotient bit.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = seq_divider_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] divisor_abs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The trial difference is one bit wider so its MSB is the borrow; no borrow
  // means the shifted remainder was >= the divisor and the subtraction stands.
  always_comb begin
    shifted = {rem_i, q_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_abs_i};
    rem_o   = shifted[WIDTH-1:0];
    q_o     = {q_i[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_o   = trial[WIDTH-1:0];
      q_o[0]  = 1'b1;
    end
  end

endmodule : seq_divider_div_step

// File: rtl/seq_divider.sv
// Multicycle signed divider with MIPS DIV semantics: LO gets the quotient
// (truncated toward zero), HI the remainder (sign of dividend), 33 cycles.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = seq_divider_pkg::WIDTH,
  parameter int CNT_W = seq_divider_pkg::CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_end_q, div_end_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1)
  // read as unsigned, which the unsigned datapath handles without overflow.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? ('0 - v) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic             neg,
                                                  input logic [WIDTH-1:0] v);
    return neg ? ('0 - v) : v;
  endfunction

  seq_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i         (rem_q),
    .q_i           (quo_q),
    .divisor_abs_i (dvs_q),
    .rem_o         (step_rem),
    .q_o           (step_quo)
  );

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_end_d  = 1'b0;
    dbz_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.div_start) begin
          if (bus.divisor == '0) begin
            // Report and stay idle; HI/LO keep the previous result.
            div_end_d = 1'b1;
            dbz_d     = 1'b1;
          end else begin
            quo_d      = magnitude(bus.dividend);
            dvs_d      = magnitude(bus.divisor);
            sign_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_rem_d = bus.dividend[WIDTH-1];
            rem_d      = '0;
            cnt_d      = '0;
            state_d    = RUN;
          end
        end
      end

      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == '1) begin
          state_d = FIX;
        end
      end

      FIX: begin
        lo_d      = apply_sign(sign_quo_q, quo_q);
        hi_d      = apply_sign(sign_rem_q, rem_q);
        div_end_d = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_end_q  <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_end_q  <= div_end_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.div_end     = div_end_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule : seq_divider

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multicycle signed 32-bit divider that responds to the control unit's divide handshake (div start pulse in, div end pulse out).
- Uses a restoring shift-subtract algorithm, one quotient bit per cycle.
- Results go to lo (quotient) and hi (remainder) with MIPS DIV semantics.
- Divide-by-zero is flagged to the controller so it can raise the DIV_ZERO exception.

Parameters:
- WIDTH, 32, operand/result width; the design is verified only at 32.
- CNT_W, 5, width of the iteration counter; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- div_start  input  1  request pulse; sampled only in IDLE
- dividend  input  WIDTH  signed dividend (rs), sampled on the accepting edge
- divisor  input  WIDTH  signed divisor (rt), sampled on the accepting edge
- busy  output  1  high while an operation is in progress
- div_end  output  1  one-cycle completion pulse
- div_by_zero  output  1  one-cycle pulse, coincident with div_end, when divisor was 0
- hi  output  WIDTH  remainder register
- lo  output  WIDTH  quotient register

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, counter=0.
  - busy=div_end=div_by_zero=0, hi=lo=0.
  - No div_end is produced for the aborted operation.
- States: IDLE, RUN, FIX.
- IDLE:
  - div_start=1 and divisor!=0 at edge E0:
    - latch |dividend| and |divisor| (two's-complement magnitude; 0x80000000 treated as unsigned 2^31);
    - latch sign_q = dividend[31]^divisor[31] and sign_r = dividend[31];
    - clear partial remainder, counter=0, busy=1, go to RUN.
  - div_start=1 and divisor==0 at E0:
    - div_end=1 and div_by_zero=1 in the cycle after E0;
    - hi/lo unchanged, stay IDLE, busy stays 0.
- RUN, one step per edge E1..E32:
  - rem = {rem[30:0], q[31]}; q = q<<1;
  - if rem >= |divisor|: rem -= |divisor|, q[0]=1;
  - counter increments; after the step where counter==31, go to FIX.
- FIX, edge E33:
  - lo = sign_q ? -q : q; hi = sign_r ? -rem : rem;
  - div_end=1 for the cycle after E33; busy=0; go to IDLE.
- Latency: div_end is high exactly in the cycle following the 33rd edge after acceptance (33 cycles start-to-end).
- Back-to-back: a new div_start may be accepted on the edge where div_end is high.
- div_end and div_by_zero are registered and last exactly one cycle.
- Arithmetic rules:
  - truncation toward zero; remainder sign follows the dividend; |hi| < |divisor|.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, no flag.
- div_start while busy: ignored; the operands in progress are unaffected.
- Operand inputs are don't-care except on the accepting edge.
- hi/lo hold their values between operations and after a divide-by-zero.

Decomposition:
- Shared package (the CPU datapath constants package): WIDTH, state encodings IDLE=2'd0, RUN=2'd1, FIX=2'd2, and the DIV_ZERO exception code constant.
- One combinational sub-module is natural: div_step. It takes (rem, q, divisor_abs) and produces the next (rem, q) for one restoring iteration.
- Sign handling and the FSM stay in seq_divider.

Test Plan:
- 100 / 7:
  - busy=1 from E0;
  - div_end pulse 33 cycles later with lo=14, hi=2, div_by_zero=0.
- Signed cases:
  - -7 / 2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - 7 / -2 gives lo=0xFFFFFFFD, hi=1;
  - -7 / -2 gives lo=3, hi=0xFFFFFFFF.
- 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- 0xFFFFFFFF / 1 gives lo=0xFFFFFFFF, hi=0.
- Divide-by-zero:
  - preload hi=2, lo=14 (100/7), then 5 / 0;
  - div_end=div_by_zero=1 in the single cycle after E0, both low the next cycle;
  - hi=2, lo=14 unchanged, busy never high.
- Mid-operation events:
  - during 100/7, pulse div_start with 9/3 at cycle 5: ignored, result still lo=14, hi=2;
  - assert rst at cycle 10 of a run: all outputs 0 immediately, no div_end ever appears;
  - after rst release, 9/3 gives lo=3, hi=0.
- Back-to-back: assert div_start with 20/6 on the div_end cycle of 100/7.
  - First op yields lo=14, hi=2.
  - Second is accepted on that edge and yields lo=3, hi=2 exactly 33 cycles later.
